dmem_responder: RTL and testbench
=================================

# dmem_responder

Responder end of the core's data-memory load/store path: a word-organised data RAM behind a valid/ready request channel and a valid/ready response channel, with a programmable wait-state count. It accepts one load or store at a time from the single-cycle core (or a later multi-cycle/pipelined core), performs byte/halfword/word access with RV32I funct3 size semantics, and returns read data or an error flag.

## Interface
- DEPTH_WORDS, 256, number of 32-bit words; legal byte addresses 0 .. 4*DEPTH_WORDS-1
- LATENCY, 2, wait cycles between request accept and response (0..15)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester takes the response
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors
- rsp_err  out  1  misaligned, out of range, or illegal size

## Operation
- Three states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch write/size/addr/wdata. Go to WAIT and load a counter with LATENCY; if LATENCY=0, go directly to RESP.
- WAIT: req_ready=0. The counter decrements each cycle. When it reaches 1, go to RESP.
- On the edge entering RESP, commit the access:
  - store: write the byte lanes.
  - load: register the extended data into rsp_rdata.
  - error: no write, rsp_rdata=0, rsp_err=1.
- RESP: rsp_valid=1. rsp_valid, rsp_rdata and rsp_err stay stable until rsp_ready=1. On that edge go to IDLE.
- Sizes:
  - 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned.
  - Stores accept only 000/001/010.
  - Any other size is an error.
- Alignment: a half with addr[0]≠0 or a word with addr[1:0]≠0 is an error.
- Range: addr[31:2] ≥ DEPTH_WORDS is an error.
- Byte lane = addr[1:0]. Store data comes from the low byte/half of req_wdata. Other lanes are untouched.
- Little-endian.

## Timing
- Reset state: IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0; every RAM word cleared to 0.
- Accept edge is cycle 0. rsp_valid is high from cycle LATENCY+1. Store data is visible to a load accepted at any later cycle.
- With rsp_ready held at 1, back-to-back spacing is LATENCY+3 cycles from accept to accept.
- req_ready is 0 in WAIT and RESP. req_valid is ignored there; the requester must hold its request.
- req_ready depends only on state, never combinationally on req_valid. There is no combinational path from rsp_ready to req_ready.
- Reset mid-transaction returns the block to IDLE immediately. A store not yet committed is dropped. A store already committed stays zero-cleared by the reset, like the rest of the RAM.
- A response held in RESP with rsp_ready=0 waits indefinitely, with outputs stable.

## Structure
- Shared package dmem_pkg:
  - mem_size_e enum: LB=3'b000, LH=3'b001, LW=3'b010, LBU=3'b100, LHU=3'b101.
  - dmem_state_e enum: IDLE, WAIT, RESP.
  - Width constants.
  - The core's decode reuses mem_size_e.
- Sub-module dmem_lane_align (combinational):
  - Inputs: size, addr[1:0], raw word.
  - Outputs: 4-bit byte-enable, shifted store word, extended load value, misalign flag.
- Top: FSM, counter, RAM array, request latch, range check.

## Test plan
- Reset, then SW 0xDEADBEEF to 0x10, then LW 0x10 → rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid first at cycle LATENCY+1 after accept.
- SB 0x80 to 0x13, then LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080; LW 0x10 → 0x80ADBEEF.
- SH to 0x11 → rsp_err=1 with no RAM change: LW 0x10 still returns 0x80ADBEEF. LW to 4*DEPTH_WORDS → rsp_err=1, rsp_rdata=0.
- Hold rsp_ready=0 for 5 cycles in RESP → rsp_valid and rsp_rdata stable, req_ready=0, a new req_valid is not accepted. Release → IDLE next cycle.
- Assert rst_n=0 during WAIT of an SW 0x12345678 to 0x20 → req_ready=1 and rsp_valid=0 immediately; after release, LW 0x20 → 0x00000000.
- Run with LATENCY=0: accept at cycle 0 → rsp_valid at cycle 1; back-to-back spacing of 3 cycles with rsp_ready tied high.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and the core's decode.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;
  localparam int BE_W   = WORD_W / 8;
  localparam int CNT_W  = 4;

  // RV32I load/store funct3 encodings; stores use only LB/LH/LW codes.
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Unsigned sizes only make sense for loads; everything else is illegal.
  function automatic logic size_legal(input logic [2:0] size, input logic write);
    case (size)
      LB, LH, LW: return 1'b1;
      LBU, LHU:   return !write;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: byte enables and replicated store data for writes,
// shifted and sign/zero-extended data for loads, plus the alignment check.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]        size,
  input  logic [1:0]        lane,
  input  logic [WORD_W-1:0] raw,
  output logic [BE_W-1:0]   byte_en,
  output logic [WORD_W-1:0] store_word,
  output logic [WORD_W-1:0] load_word,
  output logic              misalign
);

  logic [WORD_W-1:0] shifted;
  logic              is_unsigned;

  // Little-endian: lane 0 is the least significant byte.
  assign shifted     = raw >> {lane, 3'b000};
  assign is_unsigned = size[2];

  // Decode access width; illegal sizes leave everything quiet and are flagged by the top.
  always_comb begin
    byte_en    = '0;
    store_word = raw;
    load_word  = '0;
    misalign   = 1'b0;
    case (size[1:0])
      2'b00: begin
        byte_en    = 4'b0001 << lane;
        store_word = {4{raw[7:0]}};
        load_word  = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        byte_en    = 4'b0011 << lane;
        store_word = {2{raw[15:0]}};
        load_word  = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
        misalign   = lane[0];
      end
      2'b10: begin
        byte_en    = 4'b1111;
        store_word = raw;
        load_word  = shifted;
        misalign   = |lane;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Word-organised data RAM behind valid/ready request and response channels,
// with a fixed number of wait states between accept and response.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int                IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0]  LAT_L   = CNT_W'(LATENCY);
  localparam logic [ADDR_W-3:0] DEPTH_L = (ADDR_W-2)'(DEPTH_WORDS);

  dmem_state_e       state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  logic              write_reg;
  logic [2:0]        size_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [WORD_W-1:0] wdata_reg;
  logic [WORD_W-1:0] rdata_reg;
  logic              err_reg;

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  logic              accept;
  logic              commit;
  logic              op_write;
  logic [2:0]        op_size;
  logic [ADDR_W-1:0] op_addr;
  logic [WORD_W-1:0] op_wdata;
  logic [IDX_W-1:0]  op_idx;
  logic              range_err;
  logic              op_err;
  logic [WORD_W-1:0] mem_word;
  logic [BE_W-1:0]   byte_en;
  logic [WORD_W-1:0] store_word;
  logic [WORD_W-1:0] load_word;
  logic              misalign;

  assign accept = (state_reg == IDLE) && req_valid;

  // With zero latency the commit happens on the accept edge itself, so the
  // operation is taken straight from the request port while still in IDLE.
  assign op_write = (state_reg == IDLE) ? req_write : write_reg;
  assign op_size  = (state_reg == IDLE) ? req_size  : size_reg;
  assign op_addr  = (state_reg == IDLE) ? req_addr  : addr_reg;
  assign op_wdata = (state_reg == IDLE) ? req_wdata : wdata_reg;

  assign op_idx    = op_addr[2 +: IDX_W];
  assign range_err = op_addr[ADDR_W-1:2] >= DEPTH_L;
  assign mem_word  = range_err ? '0 : mem[op_idx];
  assign op_err    = !size_legal(op_size, op_write) || misalign || range_err;
  assign commit    = (state_next == RESP) && (state_reg != RESP);

  dmem_lane_align u_align (
    .size       (op_size),
    .lane       (op_addr[1:0]),
    .raw        (op_write ? op_wdata : mem_word),
    .byte_en    (byte_en),
    .store_word (store_word),
    .load_word  (load_word),
    .misalign   (misalign)
  );

  // Next-state logic; handshake readiness depends on state only.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cnt_next   = LAT_L;
          state_next = (LAT_L == '0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_reg <= CNT_W'(1)) state_next = RESP;
        else                      cnt_next   = CNT_W'(cnt_reg - 1'b1);
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Capture the request so the requester may drop it after the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_reg <= 1'b0;
      size_reg  <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (accept) begin
      write_reg <= req_write;
      size_reg  <= req_size;
      addr_reg  <= req_addr;
      wdata_reg <= req_wdata;
    end
  end

  // Response registers, loaded once on entering RESP and held until the next commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else if (commit) begin
      err_reg   <= op_err;
      rdata_reg <= (op_err || op_write) ? '0 : load_word;
    end
  end

  // RAM: cleared by reset, byte-lane writes only for legal stores.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (commit && op_write && !op_err) begin
      for (int b = 0; b < BE_W; b++) begin
        if (byte_en[b]) mem[op_idx][8*b +: 8] <= store_word[8*b +: 8];
      end
    end
  end

  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with LATENCY=2, one with LATENCY=0.
module tb_dmem_responder;

  localparam int LAT0 = 2;
  localparam int LAT1 = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [2:0]  req_size  [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  logic [7:0]  bmem [2][1024];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT0)) u_dut_l2 (
    .clk(clk), .rst_n(rst_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_size(req_size[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT1)) u_dut_l0 (
    .clk(clk), .rst_n(rst_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_size(req_size[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic clear_model(input int d);
    for (int i = 0; i < 1024; i++) bmem[d][i] = 8'h00;
  endtask

  // Byte-addressed reference memory: computes the expected response and applies stores.
  task automatic model(input int d, input logic w, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] r, output logic e);
    logic legal;
    int   n;
    int   base;
    r     = 32'h0;
    legal = w ? (sz inside {3'd0, 3'd1, 3'd2}) : (sz inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    n     = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
    e     = !legal || ((int'(a[1:0]) % n) != 0) || (a >= 32'd1024);
    if (!e) begin
      base = int'(a[9:0]);
      if (w) begin
        for (int i = 0; i < n; i++) bmem[d][base + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) r[8*i +: 8] = bmem[d][base + i];
        if (!sz[2] && n == 1) r = {{24{r[7]}}, r[7:0]};
        if (!sz[2] && n == 2) r = {{16{r[15]}}, r[15:0]};
      end
    end
  endtask

  // One request/response; expectations come from the model or from the explicit values.
  task automatic txn(input int d, input logic w, input logic [2:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input logic use_model, input logic [31:0] xr,
                     input logic xe, input int hold);
    exp_t        e;
    logic [31:0] mr;
    logic        me;
    int          k;
    int          lat;
    bit          ok;
    lat = (d == 0) ? LAT0 : LAT1;
    model(d, w, sz, a, wd, mr, me);
    if (use_model) begin e.rdata = mr; e.err = me; end
    else           begin e.rdata = xr; e.err = xe; end
    sb.push_back(e);

    @(negedge clk);
    req_valid[d] = 1'b1; req_write[d] = w; req_size[d] = sz;
    req_addr[d]  = a;    req_wdata[d] = wd; rsp_ready[d] = 1'b0;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (req_ready[d]) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid[d] = 1'b0;
      void'(sb.pop_front());
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    ok = 0;
    for (k = 1; k <= 100; k++) begin
      if (rsp_valid[d]) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
      return;
    end
    chk("rsp_first_edge", 32'(k), 32'(lat + 1));

    // Stall the response while offering a competing request that must be ignored.
    if (hold > 0) begin
      req_valid[d] = 1'b1; req_write[d] = 1'b0; req_size[d] = 3'd2; req_addr[d] = 32'h0;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
        chk("hold_rdata", rsp_rdata[d], sb[0].rdata);
        chk("hold_ready", 32'(req_ready[d]), 32'd0);
      end
      req_valid[d] = 1'b0;
    end

    e = sb.pop_front();
    chk("rsp_rdata", rsp_rdata[d], e.rdata);
    chk("rsp_err", 32'(rsp_err[d]), 32'(e.err));
    $display("txn dut%0d %s size=%0d addr=%08h wdata=%08h -> rdata=%08h err=%0b",
             d, w ? "ST" : "LD", sz, a, wd, rsp_rdata[d], rsp_err[d]);
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    chk("idle_after_rsp", {30'd0, rsp_valid[d], req_ready[d]}, 32'd1);
  endtask

  // Held request with rsp_ready high; counts edges from one accept through the next inclusive.
  task automatic b2b(input int d);
    int acc[2];
    int cnt;
    int lat;
    lat = (d == 0) ? LAT0 : LAT1;
    cnt = 0;
    @(negedge clk);
    rsp_ready[d] = 1'b1; req_valid[d] = 1'b1; req_write[d] = 1'b0;
    req_size[d]  = 3'd2; req_addr[d]  = 32'h10;
    for (int n = 0; n < 60 && cnt < 2; n++) begin
      @(negedge clk);
      if (req_ready[d]) begin acc[cnt] = n; cnt++; end
    end
    if (cnt < 2) begin
      chk("b2b_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      chk("b2b_span", 32'(acc[1] - acc[0] + 1), 32'(lat + 3));
      $display("txn dut%0d b2b LW 0x10 accept-to-accept edges=%0d", d, acc[1] - acc[0]);
    end
    @(negedge clk);
    req_valid[d] = 1'b0;
    for (int n = 0; n < 50 && !req_ready[d]; n++) @(negedge clk);
    chk("b2b_drained", 32'(req_ready[d]), 32'd1);
    rsp_ready[d] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_write[d] = 1'b0; req_size[d] = 3'd0;
      req_addr[d] = 32'h0; req_wdata[d] = 32'h0; rsp_ready[d] = 1'b0;
      clear_model(d);
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_req_ready", 32'(req_ready[d]), 32'd1);
      chk("reset_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata[d], 32'h0);
      chk("reset_rsp_err", 32'(rsp_err[d]), 32'd0);
      rst_n[d] = 1'b1;
    end

    // Directed sequence on the LATENCY=2 instance.
    txn(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 0);
    txn(0, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 0);
    txn(0, 1'b1, 3'd0, 32'h13, 32'h00000080, 1'b0, 32'h0, 1'b0, 0);
    txn(0, 1'b0, 3'd0, 32'h13, 32'h0, 1'b0, 32'hFFFFFF80, 1'b0, 0);
    txn(0, 1'b0, 3'd4, 32'h13, 32'h0, 1'b0, 32'h00000080, 1'b0, 0);
    txn(0, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'h80ADBEEF, 1'b0, 0);
    txn(0, 1'b1, 3'd1, 32'h11, 32'h0000CAFE, 1'b0, 32'h0, 1'b1, 0);
    txn(0, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'h80ADBEEF, 1'b0, 0);
    txn(0, 1'b0, 3'd2, 32'h400, 32'h0, 1'b0, 32'h0, 1'b1, 0);
    txn(0, 1'b0, 3'd5, 32'h12, 32'h0, 1'b0, 32'h000080AD, 1'b0, 0);
    txn(0, 1'b1, 3'd4, 32'h14, 32'h0, 1'b0, 32'h0, 1'b1, 0);
    txn(0, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'h80ADBEEF, 1'b0, 5);
    b2b(0);

    // Reset while a store waits: nothing committed, RAM cleared.
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_size[0] = 3'd2;
    req_addr[0]  = 32'h20; req_wdata[0] = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst_n[0] = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(req_ready[0]), 32'd1);
    chk("midrst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    $display("txn dut0 ST size=2 addr=00000020 wdata=12345678 -> dropped by reset");
    @(negedge clk);
    rst_n[0] = 1'b1;
    clear_model(0);
    txn(0, 1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 32'h00000000, 1'b0, 0);
    txn(0, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'h00000000, 1'b0, 0);

    // Zero-latency instance: directed, then randomised against the byte model.
    txn(1, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 0);
    txn(1, 1'b1, 3'd1, 32'h12, 32'h0000A55A, 1'b0, 32'h0, 1'b0, 0);
    txn(1, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'hA55ABEEF, 1'b0, 0);
    txn(1, 1'b0, 3'd1, 32'h12, 32'h0, 1'b0, 32'hFFFFA55A, 1'b0, 0);
    txn(1, 1'b0, 3'd7, 32'h10, 32'h0, 1'b0, 32'h0, 1'b1, 0);
    txn(1, 1'b0, 3'd2, 32'h3FC, 32'h0, 1'b0, 32'h0, 1'b0, 2);
    b2b(1);
    for (int i = 0; i < 30; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? 32'h400 + 32'($urandom_range(0, 15))
                                      : 32'h40 + 32'($urandom_range(0, 31));
      txn(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 1'b1,
          32'h0, 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
